// File: rtl/serial_pkg.sv
// serial_pkg: shared types and defaults for the bit-serial operand feeder
package serial_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int WIDTH_DEF = 16;
endpackage

// File: rtl/serial_operand_feeder_if.sv
// serial_operand_feeder_if: parallel operand handshake plus serial bit stream toward the adder
interface serial_operand_feeder_if import serial_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             ser_ready;
    logic             ser_valid;
    logic             ser_a;
    logic             ser_b;
    logic             ser_cin;
    logic             ser_first;
    logic             ser_last;
    logic             done;
    modport master (
        output in_valid, in_a, in_b, in_sub, ser_ready,
        input  in_ready, ser_valid, ser_a, ser_b, ser_cin, ser_first, ser_last, done
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, ser_ready,
        output in_ready, ser_valid, ser_a, ser_b, ser_cin, ser_first, ser_last, done
    );
endinterface

// File: rtl/serial_piso.sv
// serial_piso: parallel-load, shift-right register exposing its lsb
module serial_piso #(parameter int WIDTH = 16) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             lsb
);
    logic [WIDTH-1:0] q;
    // load wins over shift; shifting moves toward the lsb with zero fill
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (load) q <= d;
        else if (shift) q <= {1'b0, q[WIDTH-1:1]};
    end
    assign lsb = q[0];
endmodule

// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: streams operand pairs LSB-first to a bit-serial adder (subtract mode under SERIAL_SUB_EN)
module serial_operand_feeder import serial_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic clk,
    input logic rst,
    serial_operand_feeder_if.slave bus
);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic accept, step, first, last, sa0, sb0, sub;

    assign accept = (state == IDLE) && bus.in_valid;
    assign step   = (state == SHIFT) && bus.ser_ready;
    assign first  = cnt == '0;
    assign last   = cnt == CNT_W'(WIDTH - 1);

    serial_piso #(.WIDTH(WIDTH)) u_pa (.clk(clk), .rst(rst), .load(accept), .shift(step), .d(bus.in_a), .lsb(sa0));
    serial_piso #(.WIDTH(WIDTH)) u_pb (.clk(clk), .rst(rst), .load(accept), .shift(step), .d(bus.in_b), .lsb(sb0));

`ifdef SERIAL_SUB_EN
    // subtract flag captured with the operands and held for the whole frame
    always_ff @(posedge clk) begin
        if (rst) sub <= 1'b0;
        else if (accept) sub <= bus.in_sub;
    end
`else
    logic unused_sub;
    assign sub        = 1'b0;
    assign unused_sub = bus.in_sub;
`endif

    // bit index within the frame, restarted on every accepted pair
    always_ff @(posedge clk) begin
        if (rst || accept) cnt <= '0;
        else if (step) cnt <= cnt + 1'b1;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // next state and stream outputs; a stalled SHIFT simply holds
    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_a     = 1'b0;
        bus.ser_b     = 1'b0;
        bus.ser_cin   = 1'b0;
        bus.ser_first = 1'b0;
        bus.ser_last  = 1'b0;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nx = SHIFT;
            end
            SHIFT: begin
                bus.ser_valid = 1'b1;
                bus.ser_a     = sa0;
                bus.ser_b     = sb0 ^ sub;
                bus.ser_first = first;
                bus.ser_last  = last;
                bus.ser_cin   = sub & first;
                if (bus.ser_ready && last) state_nx = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb_serial_operand_feeder: randomized scoreboard bench with a frame-level reference model
module tb_serial_operand_feeder;
    localparam int WIDTH = 16;
    typedef struct packed {logic a; logic b; logic cin; logic first; logic last;} bit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_operand_feeder_if #(.WIDTH(WIDTH)) bus();
    serial_operand_feeder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cyc = 0;
    bit_t exp_q[$];
    logic [WIDTH:0] sum_q[$];
    bit last_flag = 1'b0;
    bit mon_en = 1'b0;
    bit stall_force = 1'b0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: a whole frame of expected bits plus the adder result it must produce
    task automatic push_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        logic se;
        bit_t e;
`ifdef SERIAL_SUB_EN
        se = s;
`else
        se = 1'b0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            e = '{a: a[i], b: b[i] ^ se, cin: (i == 0) && se, first: i == 0, last: i == WIDTH - 1};
            exp_q.push_back(e);
        end
        sum_q.push_back({1'b0, a} + {1'b0, se ? ~b : b} + (WIDTH+1)'(se));
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        bit hs = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_sub = s;
        for (int k = 0; k < 200 && !hs; k++) begin
            @(negedge clk);
            hs = bus.in_ready && !rst;
            if (hs) acc_cyc = cyc;
            @(posedge clk);
        end
        if (hs) push_frame(a, b, s);
        else chk("accept_timeout", 64'(0), 64'(1));
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n0 = done_cnt;
        for (int k = 0; k < 300 && done_cnt == n0; k++) @(posedge clk);
        if (done_cnt == n0) chk("done_timeout", 64'(0), 64'(1));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.ser_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.ser_ready = stall_force ? 1'b0 : rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // monitor: compares every presented bit against the queue head, pops on consumption
    initial begin
        bit ed;
        bit_t e;
        logic [WIDTH-1:0] acc = '0;
        logic c = 1'b0;
        int idx = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                ed = last_flag;
                chk("done", 64'(bus.done), 64'(ed));
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() == 0 && !ed));
                chk("ser_valid", 64'(bus.ser_valid), 64'(exp_q.size() != 0));
                last_flag = 1'b0;
                if (bus.ser_valid && exp_q.size() != 0) begin
                    e = exp_q[0];
                    chk("ser_a", 64'(bus.ser_a), 64'(e.a));
                    chk("ser_b", 64'(bus.ser_b), 64'(e.b));
                    chk("ser_cin", 64'(bus.ser_cin), 64'(e.cin));
                    chk("ser_first", 64'(bus.ser_first), 64'(e.first));
                    chk("ser_last", 64'(bus.ser_last), 64'(e.last));
                    if (bus.ser_ready) begin
                        void'(exp_q.pop_front());
                        if (e.first) begin
                            c = bus.ser_cin;
                            idx = 0;
                            acc = '0;
                        end
                        if (idx < WIDTH) acc[idx] = bus.ser_a ^ bus.ser_b ^ c;
                        c = (bus.ser_a & bus.ser_b) | (c & (bus.ser_a ^ bus.ser_b));
                        idx++;
                        if (e.last) begin
                            last_flag = 1'b1;
                            if (sum_q.size() != 0) chk("adder_sum", 64'({c, acc}), 64'(sum_q.pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int a1;
        int n0;
        bus.in_valid = 1'b1;
        bus.in_a = 16'h1234;
        bus.in_b = 16'h0001;
        bus.in_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.in_valid = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_outputs", 64'({bus.ser_valid, bus.ser_a, bus.ser_b, bus.ser_cin, bus.ser_first,
            bus.ser_last, bus.done, bus.in_ready}), 64'(8'b0000_0001));
        @(posedge clk);
        #1;
        send(16'h0003, 16'h0001, 1'b0);
        wait_done();
        chk("latency_basic", 64'(done_cyc - acc_cyc), 64'(WIDTH + 1));
        send(16'h1111, 16'h2222, 1'b0);
        a1 = acc_cyc;
        send(16'h3333, 16'h4444, 1'b0);
        chk("accept_gap", 64'(acc_cyc - a1), 64'(WIDTH + 2));
        wait_done();
        send(16'hA5A5, 16'h5A5A, 1'b0);
        repeat (7) @(posedge clk);
        stall_force = 1'b1;
        repeat (3) @(posedge clk);
        stall_force = 1'b0;
        wait_done();
        chk("latency_stall", 64'(done_cyc - acc_cyc), 64'(WIDTH + 4));
        send(16'hFFFF, 16'h0F0F, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        exp_q.delete();
        sum_q.delete();
        last_flag = 1'b0;
        #1 rst = 1'b0;
        n0 = done_cnt;
        repeat (20) @(posedge clk);
        chk("no_done_after_reset", 64'(done_cnt), 64'(n0));
        #1;
        send(16'h00FF, 16'h0001, 1'b0);
        wait_done();
        send(16'h0005, 16'h0003, 1'b1);
        wait_done();
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("drain", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Upstream stage of the bit-serial adder `serial`.
- Accepts two parallel WIDTH-bit operands through a valid/ready handshake.
- Streams them to the adder LSB-first, one bit pair per clock, and marks the frame boundaries.
- Supplies the carry-in for bit 0, so the adder's carry flop can be cleared or preset at each frame start.

Parameters:
- WIDTH, 16, operand width in bits and frame length in bit-cycles. Legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  feeder can accept a pair
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_sub  input  1  request A−B; ignored unless SERIAL_SUB_EN is defined
- ser_ready  input  1  adder consumes the current bit this cycle; low stalls the stream
- ser_valid  output  1  ser_a/ser_b/ser_cin are meaningful
- ser_a  output  1  current bit of A
- ser_b  output  1  current bit of B, inverted when subtracting
- ser_cin  output  1  carry-in for this bit; meaningful only while ser_first=1
- ser_first  output  1  bit 0 of the frame
- ser_last  output  1  bit WIDTH−1 of the frame
- done  output  1  one-cycle pulse after the last bit is consumed

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE; counter=0; shift registers=0. Outputs: in_ready=1, ser_valid=0, ser_a=0, ser_b=0, ser_cin=0, ser_first=0, ser_last=0, done=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, load in_a/in_b into shift registers sa/sb, latch the sub flag, set counter=0, go to SHIFT.
- SHIFT:
  - ser_valid=1; ser_a=sa[0]; ser_b=sb[0]^sub.
  - ser_first=(counter==0); ser_last=(counter==WIDTH−1).
  - ser_cin=sub when ser_first, else 0.
  - On ser_ready=1: shift sa/sb right by one (zero fill) and increment the counter. If ser_last, go to DONE.
  - On ser_ready=0: hold all state and outputs unchanged.
- DONE: done=1 and in_ready=0 for exactly one cycle, then go to IDLE.
- Latency with ser_ready tied high:
  - Handshake at edge T. Bit 0 is presented in cycle T+1 and bit WIDTH−1 in cycle T+WIDTH.
  - done is high in cycle T+WIDTH+1; in_ready is high again in cycle T+WIDTH+2.
  - Throughput is one pair per WIDTH+2 cycles.
- in_ready=0 throughout SHIFT and DONE. Operands offered then are not accepted and must be held by the source.
- Counter never wraps inside a frame. It is reloaded to 0 on every accept.
- Reset asserted mid-frame:
  - The frame is abandoned; outputs return to reset values on the next edge.
  - No done pulse is produced for the abandoned frame.
- rst together with in_valid: reset wins, nothing is accepted.
- ser_ready=0 on the last bit: stay in SHIFT with ser_last=1 until it is consumed.

Optional Feature:
- Macro SERIAL_SUB_EN.
- Defined:
  - in_sub is latched on accept.
  - When sub=1, every ser_b bit is inverted and ser_cin=1 on bit 0, so the adder computes A+~B+1 = A−B mod 2^WIDTH.
- Undefined:
  - in_sub is ignored, sub is treated as 0, ser_b=sb[0], ser_cin=0 always.
  - No sub register is synthesised.

Decomposition:
- Shared package serial_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - default WIDTH constant 16.
- Natural sub-module: serial_piso, a WIDTH-bit parallel-load, shift-right register with load/shift enables. Instantiated twice, for A and B.
- FSM and counter stay in the top module.

Test Plan:
- Reset then idle: rst high 2 cycles → all outputs at reset values, in_ready=1.
- Basic frame: in_a=16'h0003, in_b=16'h0001, ser_ready=1.
  - ser_a sequence 1,1,0…0 and ser_b sequence 1,0…0.
  - ser_first high in bit-cycle 0 only, ser_last in bit-cycle 15 only.
  - done at T+17; the downstream serial adder yields sum=16'h0004, cout=0.
- Stall: toggle ser_ready low for 3 cycles at bit 7 with in_a=16'hA5A5 → bits held unchanged while stalled, all 16 bits delivered in order, done delayed by exactly 3 cycles.
- Back-pressure on input: in_valid held high with a second pair during a frame → second pair accepted only in IDLE at T+18, not before.
- Reset mid-frame: rst at bit 9 → next cycle ser_valid=0, in_ready=1, no done pulse; a following frame completes normally.
- SERIAL_SUB_EN defined: in_a=16'h0005, in_b=16'h0003, in_sub=1 → ser_b = bits of 16'hFFFC, ser_cin=1 on bit 0; the adder yields sum=16'h0002, cout=1.
